// File: rtl/acc_alu.sv
// acc_alu: accumulator + ALU stage fed by the CPU1 A-operand mux.
// Single-cycle ops write acc/flags at the accept edge; MUL is a WIDTH-cycle
// iterative shift-add whose result becomes visible only on completion.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   a_in            operand from the A-operand mux
//   alu_op, start   opcode and request (accepted only while busy==0)
//   busy            high while a MUL is iterating
//   done            one-cycle pulse once acc/flags hold a new result
//   acc, prod_hi    accumulator and upper half of the last MUL product
//   zero, carry     registered flags
module acc_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [3:0]       alu_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] prod_hi,
    output logic             zero,
    output logic             carry
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    prod;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic             alu_wr;
    logic [WIDTH:0]   ext;
    logic [PW-1:0]    prod_next;

    // Single-cycle result; alu_wr is low for NOP, MUL and undefined opcodes.
    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        alu_wr  = 1'b0;
        ext     = '0;
        case (alu_op)
            OP_LOAD: begin alu_res = a_in; alu_wr = 1'b1; end
            OP_ADD: begin
                ext     = (WIDTH+1)'(acc) + (WIDTH+1)'(a_in);
                alu_res = ext[WIDTH-1:0];
                alu_cy  = ext[WIDTH];
                alu_wr  = 1'b1;
            end
            OP_SUB: begin
                // bit WIDTH of the widened difference is the unsigned borrow
                ext     = (WIDTH+1)'(acc) - (WIDTH+1)'(a_in);
                alu_res = ext[WIDTH-1:0];
                alu_cy  = ext[WIDTH];
                alu_wr  = 1'b1;
            end
            OP_AND: begin alu_res = acc & a_in; alu_wr = 1'b1; end
            OP_OR:  begin alu_res = acc | a_in; alu_wr = 1'b1; end
            OP_XOR: begin alu_res = acc ^ a_in; alu_wr = 1'b1; end
            OP_SHL: begin
                alu_res = {acc[WIDTH-2:0], 1'b0};
                alu_cy  = acc[WIDTH-1];
                alu_wr  = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, acc[WIDTH-1:1]};
                alu_cy  = acc[0];
                alu_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    assign prod_next = prod + (mplier[0] ? mcand : PW'(0));

    // Control FSM and all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc     <= '0;
            prod_hi <= '0;
            zero    <= 1'b1;
            carry   <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (alu_op == OP_MUL) begin
                            mcand  <= PW'(acc);
                            mplier <= a_in;
                            prod   <= '0;
                            count  <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= S_MUL;
                        end else begin
                            done <= 1'b1;
                            if (alu_wr) begin
                                acc   <= alu_res;
                                carry <= alu_cy;
                                zero  <= (alu_res == '0);
                            end
                        end
                    end
                end
                S_MUL: begin
                    prod   <= prod_next;
                    mcand  <= {mcand[PW-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        acc     <= prod_next[WIDTH-1:0];
                        prod_hi <= prod_next[PW-1:WIDTH];
                        carry   <= (prod_next[PW-1:WIDTH] != '0);
                        zero    <= (prod_next[WIDTH-1:0] == '0);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_alu.sv
// Directed testbench for acc_alu (WIDTH=8).
module tb_acc_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_in;
    logic [3:0] alu_op;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] acc;
    logic [7:0] prod_hi;
    logic       zero;
    logic       carry;

    int total = 0;
    int bad   = 0;

    acc_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .alu_op(alu_op), .start(start),
        .busy(busy), .done(done), .acc(acc), .prod_hi(prod_hi),
        .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    // Present a request for one edge; returns 1 ns after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a);
        @(negedge clk);
        alu_op = op;
        a_in   = a;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait out busy (bounded); returns cycles observed with busy high.
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = '0; alu_op = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({acc, prod_hi, zero, carry, busy, done} !== {8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: acc=%0d ph=%0d z=%b c=%b busy=%b done=%b, want 0 0 1 0 0 0",
                     acc, prod_hi, zero, carry, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        issue(4'd1, 8'd200);
        total++;
        if (done !== 1'b1 || acc !== 8'd200 || carry !== 1'b0) begin
            bad++; $display("FAIL load200: done=%b acc=%0d c=%b, want 1 200 0", done, acc, carry);
        end
        issue(4'd2, 8'd100);
        total++;
        if (done !== 1'b1 || acc !== 8'd44 || carry !== 1'b1 || zero !== 1'b0) begin
            bad++; $display("FAIL add: done=%b acc=%0d c=%b z=%b, want 1 44 1 0", done, acc, carry, zero);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || acc !== 8'd44) begin
            bad++; $display("FAIL add_pulse: done=%b acc=%0d, want 0 44", done, acc);
        end
    endtask

    task automatic test_sub();
        issue(4'd1, 8'd5);
        issue(4'd3, 8'd9);
        total++;
        if (acc !== 8'd252 || carry !== 1'b1 || zero !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL sub_borrow: acc=%0d c=%b z=%b d=%b, want 252 1 0 1", acc, carry, zero, done);
        end
        issue(4'd3, 8'd252);
        total++;
        if (acc !== 8'd0 || carry !== 1'b0 || zero !== 1'b1) begin
            bad++; $display("FAIL sub_zero: acc=%0d c=%b z=%b, want 0 0 1", acc, carry, zero);
        end
    endtask

    task automatic test_mul();
        int cnt;
        issue(4'd1, 8'd13);
        issue(4'd9, 8'd20);
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || acc !== 8'd13) begin
            bad++; $display("FAIL mul_start: busy=%b done=%b acc=%0d, want 1 0 13", busy, done, acc);
        end
        a_in = 8'd255; alu_op = 4'd1;
        wait_busy(cnt);
        total++;
        if (cnt !== 8) begin
            bad++; $display("FAIL mul_busy_len: got %0d cycles, want 8", cnt);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || acc !== 8'd4 || prod_hi !== 8'd1
            || carry !== 1'b1 || zero !== 1'b0) begin
            bad++; $display("FAIL mul_result: d=%b b=%b acc=%0d ph=%0d c=%b z=%b, want 1 0 4 1 1 0",
                            done, busy, acc, prod_hi, carry, zero);
        end
    endtask

    task automatic test_back_to_back();
        // AND accepted in the cycle done is high after the MUL
        issue(4'd4, 8'h0F);
        total++;
        if (done !== 1'b1 || acc !== 8'd4 || carry !== 1'b0 || prod_hi !== 8'd1) begin
            bad++; $display("FAIL b2b_and: d=%b acc=%0d c=%b ph=%0d, want 1 4 0 1", done, acc, carry, prod_hi);
        end
        issue(4'd5, 8'hF0);
        total++;
        if (done !== 1'b1 || acc !== 8'hF4) begin
            bad++; $display("FAIL b2b_or: d=%b acc=%h, want 1 f4", done, acc);
        end
    endtask

    task automatic test_ignore_start();
        int cnt;
        issue(4'd1, 8'd13);
        issue(4'd9, 8'd20);
        @(posedge clk); #1;
        @(negedge clk);
        alu_op = 4'd1; a_in = 8'd99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (acc !== 8'd13 || done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL ignore_load: acc=%0d d=%b b=%b, want 13 0 1", acc, done, busy);
        end
        wait_busy(cnt);
        total++;
        if (done !== 1'b1 || acc !== 8'd4 || prod_hi !== 8'd1 || carry !== 1'b1) begin
            bad++; $display("FAIL ignore_result: d=%b acc=%0d ph=%0d c=%b, want 1 4 1 1", done, acc, prod_hi, carry);
        end
    endtask

    task automatic test_abort();
        int pulses;
        issue(4'd1, 8'd13);
        issue(4'd9, 8'd20);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (acc !== 8'd0 || prod_hi !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
            bad++; $display("FAIL abort: acc=%0d ph=%0d b=%b d=%b z=%b, want 0 0 0 0 1", acc, prod_hi, busy, done, zero);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL abort_quiet: %0d done/busy cycles, want 0", pulses);
        end
    endtask

    task automatic test_shift_logic();
        issue(4'd1, 8'h81);
        issue(4'd7, 8'h00);
        total++;
        if (acc !== 8'h02 || carry !== 1'b1) begin
            bad++; $display("FAIL shl: acc=%h c=%b, want 02 1", acc, carry);
        end
        issue(4'd8, 8'h00);
        total++;
        if (acc !== 8'h01 || carry !== 1'b0) begin
            bad++; $display("FAIL shr: acc=%h c=%b, want 01 0", acc, carry);
        end
        issue(4'd6, 8'h01);
        total++;
        if (acc !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
            bad++; $display("FAIL xor: acc=%h z=%b c=%b, want 00 1 0", acc, zero, carry);
        end
        issue(4'd15, 8'hAA);
        total++;
        if (done !== 1'b1 || acc !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
            bad++; $display("FAIL op15: d=%b acc=%h z=%b c=%b, want 1 00 1 0", done, acc, zero, carry);
        end
        // SHL of 0x80 leaves carry=1 and zero=1 for the NOP to preserve
        issue(4'd1, 8'h80);
        issue(4'd7, 8'h00);
        issue(4'd0, 8'h55);
        total++;
        if (done !== 1'b1 || acc !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin
            bad++; $display("FAIL nop: d=%b acc=%h z=%b c=%b, want 1 00 1 1", done, acc, zero, carry);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_shift_logic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
